scan_for_test_chain: RTL and testbench

- Single-clock scan-chain bridge between chip pads and two access groups, A and B.
- Each group drives one SRAM port (11-bit address, 32-bit data) and one control-register pair (17-bit ctr1, 15-bit ctr2).
- The off-chip scan master shifts a 143-bit command/response frame through the pads.
- scan_id selects which group a frame is loaded into and captured from.

---
 rtl/scan_for_test_pkg.sv | 45 ++++
 rtl/scan_group_port.sv | 156 +++++++++++++++
 rtl/scan_for_test_chain.sv | 195 +++++++++++++++++++
 tb/tb_scan_for_test_chain.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_for_test_pkg.sv
// ============================================================================
// Package : scan_for_test_pkg
// Purpose : Shared widths, scan-frame layout and FSM state type for the
//           scan_for_test_chain bridge.
// Contents: field widths, CHAIN_LEN, read-field offsets, frame_t, grp_state_e
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package scan_for_test_pkg;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 32;
  localparam int CTR1_W    = 17;
  localparam int CTR2_W    = 15;
  localparam int CHAIN_LEN = 4 + ADDR_W + 2*DATA_W + 2*CTR1_W + 2*CTR2_W;

  // Bit offsets of the response fields inside the chain (LSB = bit 0)
  localparam int OFS_RDATA      = 2 + ADDR_W + DATA_W;
  localparam int OFS_CTR1_RDATA = OFS_RDATA + DATA_W + 2 + CTR1_W;
  localparam int OFS_CTR2_RDATA = OFS_CTR1_RDATA + CTR1_W + CTR2_W;

  // Frame layout; first member is the MSB end of the chain
  typedef struct packed {
    logic [CTR2_W-1:0] ctr2_rdata;
    logic [CTR2_W-1:0] ctr2_wdata;
    logic [CTR1_W-1:0] ctr1_rdata;
    logic [CTR1_W-1:0] ctr1_wdata;
    logic              ctr_wen;
    logic              ctr_ren;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
    logic              sram_wen;
    logic              sram_ren;
  } frame_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } grp_state_e;

endpackage

`default_nettype wire

// File: rtl/scan_group_port.sv
// ============================================================================
// Module  : scan_group_port
// Purpose : One access group: latches a command on load_i, holds SRAM and
//           control-register requests until their ready, captures read data.
// Ports   : clk, rst, load_i            - clock, async reset, command strobe
//           *_i command fields          - write/command fields from the chain
//           sram_*/ctr_* rdata/ready_i  - target responses
//           sram_*/ctr_* _o             - request outputs to the targets
//           rsp_*_o                     - captured read responses
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_group_port
  import scan_for_test_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              sram_ren_i,
  input  logic              sram_wen_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              ctr_ren_i,
  input  logic              ctr_wen_i,
  input  logic [CTR1_W-1:0] ctr1_wdata_i,
  input  logic [CTR2_W-1:0] ctr2_wdata_i,
  input  logic [DATA_W-1:0] sram_rdata_i,
  input  logic              sram_ready_i,
  input  logic [CTR1_W-1:0] ctr1_rdata_i,
  input  logic [CTR2_W-1:0] ctr2_rdata_i,
  input  logic              ctr_ready_i,
  output logic              sram_ren_o,
  output logic              sram_wen_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  output logic              ctr_ren_o,
  output logic              ctr_wen_o,
  output logic [CTR1_W-1:0] ctr1_wdata_o,
  output logic [CTR2_W-1:0] ctr2_wdata_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [CTR1_W-1:0] rsp_ctr1_o,
  output logic [CTR2_W-1:0] rsp_ctr2_o
);

  grp_state_e        state_q, state_d;
  logic              sram_ren_q, sram_ren_d, sram_wen_q, sram_wen_d;
  logic              ctr_ren_q, ctr_ren_d, ctr_wen_q, ctr_wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CTR1_W-1:0] ctr1_q, ctr1_d;
  logic [CTR2_W-1:0] ctr2_q, ctr2_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CTR1_W-1:0] rsp_ctr1_q, rsp_ctr1_d;
  logic [CTR2_W-1:0] rsp_ctr2_q, rsp_ctr2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sram_ren_q  <= 1'b0;
      sram_wen_q  <= 1'b0;
      ctr_ren_q   <= 1'b0;
      ctr_wen_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ctr1_q      <= '0;
      ctr2_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_ctr1_q  <= '0;
      rsp_ctr2_q  <= '0;
    end else begin
      state_q     <= state_d;
      sram_ren_q  <= sram_ren_d;
      sram_wen_q  <= sram_wen_d;
      ctr_ren_q   <= ctr_ren_d;
      ctr_wen_q   <= ctr_wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ctr1_q      <= ctr1_d;
      ctr2_q      <= ctr2_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_ctr1_q  <= rsp_ctr1_d;
      rsp_ctr2_q  <= rsp_ctr2_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sram_ren_d  = sram_ren_q;
    sram_wen_d  = sram_wen_q;
    ctr_ren_d   = ctr_ren_q;
    ctr_wen_d   = ctr_wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ctr1_d      = ctr1_q;
    ctr2_d      = ctr2_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_ctr1_d  = rsp_ctr1_q;
    rsp_ctr2_d  = rsp_ctr2_q;
    case (state_q)
      ST_IDLE: begin
        // A command while busy is dropped because loads are only taken here
        if (load_i) begin
          sram_ren_d = sram_ren_i;
          sram_wen_d = sram_wen_i;
          ctr_ren_d  = ctr_ren_i;
          ctr_wen_d  = ctr_wen_i;
          addr_d     = addr_i;
          wdata_d    = wdata_i;
          ctr1_d     = ctr1_wdata_i;
          ctr2_d     = ctr2_wdata_i;
          if (sram_ren_i || sram_wen_i || ctr_ren_i || ctr_wen_i) begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // SRAM and control sides complete independently
        if ((sram_ren_q || sram_wen_q) && sram_ready_i) begin
          if (sram_ren_q) begin
            rsp_rdata_d = sram_rdata_i;
          end
          sram_ren_d = 1'b0;
          sram_wen_d = 1'b0;
        end
        if ((ctr_ren_q || ctr_wen_q) && ctr_ready_i) begin
          if (ctr_ren_q) begin
            rsp_ctr1_d = ctr1_rdata_i;
            rsp_ctr2_d = ctr2_rdata_i;
          end
          ctr_ren_d = 1'b0;
          ctr_wen_d = 1'b0;
        end
        if (!(sram_ren_d || sram_wen_d || ctr_ren_d || ctr_wen_d)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sram_ren_o   = sram_ren_q;
  assign sram_wen_o   = sram_wen_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign ctr_ren_o    = ctr_ren_q;
  assign ctr_wen_o    = ctr_wen_q;
  assign ctr1_wdata_o = ctr1_q;
  assign ctr2_wdata_o = ctr2_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_ctr1_o   = rsp_ctr1_q;
  assign rsp_ctr2_o   = rsp_ctr2_q;

endmodule

`default_nettype wire

// File: rtl/scan_for_test_chain.sv
// ============================================================================
// Module  : scan_for_test_chain
// Purpose : Scan-chain bridge from chip pads to two access groups (A, B).
//           Pads are synchronised and edge-detected; a 143-bit frame is
//           shifted by phi/phi_bar pairs, applied to the selected group on
//           load_chip and refreshed with its responses on load_chain.
// Ports   : clk, rst                 - system clock, async active-high reset
//           scan_*                   - scan pad interface
//           sram_*_A/_B, ctr*_A/_B   - per-group SRAM / control-reg ports
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_for_test_chain
  import scan_for_test_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_id,
  input  logic              scan_phi,
  input  logic              scan_phi_bar,
  input  logic              scan_data_in,
  output logic              scan_data_out,
  input  logic              scan_load_chip,
  input  logic              scan_load_chain,
  output logic              sram_ren_A,
  output logic              sram_wen_A,
  output logic [ADDR_W-1:0] sram_addr_A,
  output logic [DATA_W-1:0] sram_wdata_A,
  input  logic [DATA_W-1:0] sram_rdata_A,
  input  logic              sram_ready_A,
  output logic              sram_ren_B,
  output logic              sram_wen_B,
  output logic [ADDR_W-1:0] sram_addr_B,
  output logic [DATA_W-1:0] sram_wdata_B,
  input  logic [DATA_W-1:0] sram_rdata_B,
  input  logic              sram_ready_B,
  output logic              ctr_ren_A,
  output logic              ctr_wen_A,
  output logic [CTR1_W-1:0] ctr1_wdata_A,
  output logic [CTR2_W-1:0] ctr2_wdata_A,
  input  logic [CTR1_W-1:0] ctr1_rdata_A,
  input  logic [CTR2_W-1:0] ctr2_rdata_A,
  input  logic              ctr_ready_A,
  output logic              ctr_ren_B,
  output logic              ctr_wen_B,
  output logic [CTR1_W-1:0] ctr1_wdata_B,
  output logic [CTR2_W-1:0] ctr2_wdata_B,
  input  logic [CTR1_W-1:0] ctr1_rdata_B,
  input  logic [CTR2_W-1:0] ctr2_rdata_B,
  input  logic              ctr_ready_B
);

  localparam int P_ID = 0, P_PHI = 1, P_PHIB = 2, P_DIN = 3, P_LCHIP = 4, P_LCHAIN = 5;

  logic [5:0] pad_raw, pad_s;
  logic [5:0] sync_q [SYNC_STAGES];
  logic [3:0] edge_s, prev_q, rise;
  logic       phi_rise, phib_rise, lchip_rise, lchain_rise;

  assign pad_raw = {scan_load_chain, scan_load_chip, scan_data_in,
                    scan_phi_bar, scan_phi, scan_id};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pad_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= edge_s;
    end
  end

  assign pad_s       = sync_q[SYNC_STAGES-1];
  assign edge_s      = {pad_s[P_LCHAIN], pad_s[P_LCHIP], pad_s[P_PHIB], pad_s[P_PHI]};
  assign rise        = edge_s & ~prev_q;
  assign phi_rise    = rise[0];
  assign phib_rise   = rise[1];
  assign lchip_rise  = rise[2];
  assign lchain_rise = rise[3];

  frame_t            chain_q, chain_d;
  logic              master_q, master_d, mvld_q, mvld_d;
  logic [DATA_W-1:0] rsp_rdata_A, rsp_rdata_B;
  logic [CTR1_W-1:0] rsp_ctr1_A, rsp_ctr1_B;
  logic [CTR2_W-1:0] rsp_ctr2_A, rsp_ctr2_B;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q  <= '0;
      master_q <= 1'b0;
      mvld_q   <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      master_q <= master_d;
      mvld_q   <= mvld_d;
    end
  end

  always_comb begin
    chain_d  = chain_q;
    master_d = master_q;
    mvld_d   = mvld_q;
    // phi_bar consumes the master bit; a phi_bar without a prior phi shifts nothing
    if (phib_rise) begin
      mvld_d = 1'b0;
      if (mvld_q && !lchain_rise) begin
        chain_d = frame_t'({chain_q[CHAIN_LEN-2:0], master_q});
      end
    end
    if (phi_rise) begin
      master_d = pad_s[P_DIN];
      mvld_d   = 1'b1;
    end
    if (lchain_rise) begin
      if (pad_s[P_ID]) begin
        chain_d[OFS_RDATA      +: DATA_W] = rsp_rdata_B;
        chain_d[OFS_CTR1_RDATA +: CTR1_W] = rsp_ctr1_B;
        chain_d[OFS_CTR2_RDATA +: CTR2_W] = rsp_ctr2_B;
      end else begin
        chain_d[OFS_RDATA      +: DATA_W] = rsp_rdata_A;
        chain_d[OFS_CTR1_RDATA +: CTR1_W] = rsp_ctr1_A;
        chain_d[OFS_CTR2_RDATA +: CTR2_W] = rsp_ctr2_A;
      end
    end
  end

  assign scan_data_out = chain_q[OFS_CTR2_RDATA + CTR2_W - 1];

  scan_group_port u_grp_a (
    .clk          (clk),
    .rst          (rst),
    .load_i       (lchip_rise && !pad_s[P_ID]),
    .sram_ren_i   (chain_q.sram_ren),
    .sram_wen_i   (chain_q.sram_wen),
    .addr_i       (chain_q.addr),
    .wdata_i      (chain_q.wdata),
    .ctr_ren_i    (chain_q.ctr_ren),
    .ctr_wen_i    (chain_q.ctr_wen),
    .ctr1_wdata_i (chain_q.ctr1_wdata),
    .ctr2_wdata_i (chain_q.ctr2_wdata),
    .sram_rdata_i (sram_rdata_A),
    .sram_ready_i (sram_ready_A),
    .ctr1_rdata_i (ctr1_rdata_A),
    .ctr2_rdata_i (ctr2_rdata_A),
    .ctr_ready_i  (ctr_ready_A),
    .sram_ren_o   (sram_ren_A),
    .sram_wen_o   (sram_wen_A),
    .sram_addr_o  (sram_addr_A),
    .sram_wdata_o (sram_wdata_A),
    .ctr_ren_o    (ctr_ren_A),
    .ctr_wen_o    (ctr_wen_A),
    .ctr1_wdata_o (ctr1_wdata_A),
    .ctr2_wdata_o (ctr2_wdata_A),
    .rsp_rdata_o  (rsp_rdata_A),
    .rsp_ctr1_o   (rsp_ctr1_A),
    .rsp_ctr2_o   (rsp_ctr2_A)
  );

  scan_group_port u_grp_b (
    .clk          (clk),
    .rst          (rst),
    .load_i       (lchip_rise && pad_s[P_ID]),
    .sram_ren_i   (chain_q.sram_ren),
    .sram_wen_i   (chain_q.sram_wen),
    .addr_i       (chain_q.addr),
    .wdata_i      (chain_q.wdata),
    .ctr_ren_i    (chain_q.ctr_ren),
    .ctr_wen_i    (chain_q.ctr_wen),
    .ctr1_wdata_i (chain_q.ctr1_wdata),
    .ctr2_wdata_i (chain_q.ctr2_wdata),
    .sram_rdata_i (sram_rdata_B),
    .sram_ready_i (sram_ready_B),
    .ctr1_rdata_i (ctr1_rdata_B),
    .ctr2_rdata_i (ctr2_rdata_B),
    .ctr_ready_i  (ctr_ready_B),
    .sram_ren_o   (sram_ren_B),
    .sram_wen_o   (sram_wen_B),
    .sram_addr_o  (sram_addr_B),
    .sram_wdata_o (sram_wdata_B),
    .ctr_ren_o    (ctr_ren_B),
    .ctr_wen_o    (ctr_wen_B),
    .ctr1_wdata_o (ctr1_wdata_B),
    .ctr2_wdata_o (ctr2_wdata_B),
    .rsp_rdata_o  (rsp_rdata_B),
    .rsp_ctr1_o   (rsp_ctr1_B),
    .rsp_ctr2_o   (rsp_ctr2_B)
  );

endmodule

`default_nettype wire

// File: tb/tb_scan_for_test_chain.sv
// ============================================================================
// Module  : tb_scan_for_test_chain
// Purpose : Directed self-checking bench for scan_for_test_chain.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_for_test_chain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_id = 1'b0, scan_phi = 1'b0, scan_phi_bar = 1'b0;
  logic        scan_data_in = 1'b0, scan_load_chip = 1'b0, scan_load_chain = 1'b0;
  logic        scan_data_out;
  logic        sram_ren_A, sram_wen_A, sram_ren_B, sram_wen_B;
  logic [10:0] sram_addr_A, sram_addr_B;
  logic [31:0] sram_wdata_A, sram_wdata_B;
  logic [31:0] sram_rdata_A = '0, sram_rdata_B = 32'hFFFF_FFFF;
  logic        sram_ready_A = 1'b0, sram_ready_B = 1'b0;
  logic        ctr_ren_A, ctr_wen_A, ctr_ren_B, ctr_wen_B;
  logic [16:0] ctr1_wdata_A, ctr1_wdata_B;
  logic [14:0] ctr2_wdata_A, ctr2_wdata_B;
  logic [16:0] ctr1_rdata_A = 17'h1FFFF, ctr1_rdata_B = '0;
  logic [14:0] ctr2_rdata_A = 15'h7FFF, ctr2_rdata_B = '0;
  logic        ctr_ready_A = 1'b0, ctr_ready_B = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  mem_a [0:2047];
  logic [16:0]  c1_b = '0;
  logic [14:0]  c2_b = '0;
  logic [142:0] pat, dout;

  always #5 clk = ~clk;

  scan_for_test_chain dut (
    .clk(clk), .rst(rst), .scan_id(scan_id), .scan_phi(scan_phi),
    .scan_phi_bar(scan_phi_bar), .scan_data_in(scan_data_in),
    .scan_data_out(scan_data_out), .scan_load_chip(scan_load_chip),
    .scan_load_chain(scan_load_chain),
    .sram_ren_A(sram_ren_A), .sram_wen_A(sram_wen_A), .sram_addr_A(sram_addr_A),
    .sram_wdata_A(sram_wdata_A), .sram_rdata_A(sram_rdata_A), .sram_ready_A(sram_ready_A),
    .sram_ren_B(sram_ren_B), .sram_wen_B(sram_wen_B), .sram_addr_B(sram_addr_B),
    .sram_wdata_B(sram_wdata_B), .sram_rdata_B(sram_rdata_B), .sram_ready_B(sram_ready_B),
    .ctr_ren_A(ctr_ren_A), .ctr_wen_A(ctr_wen_A), .ctr1_wdata_A(ctr1_wdata_A),
    .ctr2_wdata_A(ctr2_wdata_A), .ctr1_rdata_A(ctr1_rdata_A), .ctr2_rdata_A(ctr2_rdata_A),
    .ctr_ready_A(ctr_ready_A),
    .ctr_ren_B(ctr_ren_B), .ctr_wen_B(ctr_wen_B), .ctr1_wdata_B(ctr1_wdata_B),
    .ctr2_wdata_B(ctr2_wdata_B), .ctr1_rdata_B(ctr1_rdata_B), .ctr2_rdata_B(ctr2_rdata_B),
    .ctr_ready_B(ctr_ready_B)
  );

  task automatic chk(input string tag, input logic [142:0] obs, input logic [142:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame built from the documented bit positions
  function automatic logic [142:0] mk(input logic ren, input logic wen,
                                      input logic [10:0] a, input logic [31:0] wd,
                                      input logic cren, input logic cwen,
                                      input logic [16:0] c1, input logic [14:0] c2,
                                      input logic [14:0] c2r);
    logic [142:0] f;
    f = '0;
    f[0] = ren; f[1] = wen; f[12:2] = a; f[44:13] = wd;
    f[77] = cren; f[78] = cwen; f[95:79] = c1; f[127:113] = c2; f[142:128] = c2r;
    return f;
  endfunction

  task automatic shift_bit(input logic b);
    scan_data_in = b;
    tick(1);
    scan_phi = 1'b1;     tick(4);
    scan_phi = 1'b0;     tick(4);
    scan_phi_bar = 1'b1; tick(4);
    scan_phi_bar = 1'b0; tick(4);
  endtask

  // Exchanges a whole frame: din enters MSB first, old chain leaves MSB first
  task automatic shift_frame(input logic [142:0] din, output logic [142:0] dout_o);
    dout_o = '0;
    for (int i = 142; i >= 0; i--) begin
      dout_o[i] = scan_data_out;
      shift_bit(din[i]);
    end
  endtask

  task automatic pulse_chip();
    scan_load_chip = 1'b1;  tick(4);
    scan_load_chip = 1'b0;  tick(4);
  endtask

  task automatic pulse_chain();
    scan_load_chain = 1'b1; tick(4);
    scan_load_chain = 1'b0; tick(4);
  endtask

  task automatic sram_resp_a();
    chk("a_sram_req_held", {sram_ren_A | sram_wen_A}, 143'd1);
    if (sram_wen_A) mem_a[sram_addr_A] = sram_wdata_A;
    sram_rdata_A = mem_a[sram_addr_A];
    sram_ready_A = 1'b1;
    tick(1);
    sram_ready_A = 1'b0;
    chk("a_sram_req_drop", {sram_ren_A, sram_wen_A}, 143'd0);
    tick(2);
  endtask

  task automatic ctr_resp_b();
    chk("b_ctr_req_held", {ctr_ren_B | ctr_wen_B}, 143'd1);
    if (ctr_wen_B) begin
      c1_b = ctr1_wdata_B;
      c2_b = ctr2_wdata_B;
    end
    ctr1_rdata_B = c1_b;
    ctr2_rdata_B = c2_b;
    ctr_ready_B = 1'b1;
    tick(1);
    ctr_ready_B = 1'b0;
    chk("b_ctr_req_drop", {ctr_ren_B, ctr_wen_B}, 143'd0);
    tick(2);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem_a[i] = '0;
    tick(3);
    rst = 1'b0;
    tick(3);

    // Reset state
    chk("rst_dout", scan_data_out, 143'd0);
    chk("rst_reqs", {sram_ren_A, sram_wen_A, ctr_ren_A, ctr_wen_A,
                     sram_ren_B, sram_wen_B, ctr_ren_B, ctr_wen_B}, 143'd0);

    // Alternating pattern round-trip, first shifted bit is 1
    for (int i = 0; i < 143; i++) pat[i] = (i % 2 == 0);
    shift_frame(pat, dout);
    chk("rst_chain_zero", dout, 143'd0);
    shift_frame('0, dout);
    chk("pattern_roundtrip", dout, pat);

    // Group A write
    scan_id = 1'b0; tick(4);
    shift_frame(mk(1'b0, 1'b1, 11'h005, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0, '0), dout);
    pulse_chip();
    chk("a_wen", {sram_ren_A, sram_wen_A}, 143'd1);
    chk("a_addr", sram_addr_A, 143'h005);
    chk("a_wdata", sram_wdata_A, 143'hDEAD_BEEF);
    chk("b_idle", {sram_ren_B, sram_wen_B, ctr_ren_B, ctr_wen_B, sram_addr_B, sram_wdata_B}, 143'd0);
    tick(10);
    sram_resp_a();

    // Group A read back
    shift_frame(mk(1'b1, 1'b0, 11'h005, '0, 1'b0, 1'b0, '0, '0, '0), dout);
    pulse_chip();
    chk("a_ren", {sram_ren_A, sram_wen_A}, 143'd2);
    sram_resp_a();
    pulse_chain();
    shift_frame('0, dout);
    chk("a_rdata_field", dout[76:45], 143'hDEAD_BEEF);
    chk("a_cmd_preserved", {dout[12:2], dout[1:0]}, {11'h005, 2'b01});

    // Group B control write then read
    scan_id = 1'b1; tick(4);
    shift_frame(mk(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 17'h1ABCD, 15'h5A5A, '0), dout);
    pulse_chip();
    chk("b_ctr_wen", {ctr_ren_B, ctr_wen_B}, 143'd1);
    chk("b_ctr_wdata", {ctr1_wdata_B, ctr2_wdata_B}, {17'h1ABCD, 15'h5A5A});
    chk("a_ctr_idle", {ctr_ren_A, ctr_wen_A, sram_ren_A, sram_wen_A}, 143'd0);
    ctr_resp_b();
    shift_frame(mk(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0, '0), dout);
    pulse_chip();
    chk("b_ctr_ren", {ctr_ren_B, ctr_wen_B}, 143'd2);
    ctr_resp_b();
    pulse_chain();
    shift_frame('0, dout);
    chk("b_ctr1_field", dout[112:96], 143'h1ABCD);
    chk("b_ctr2_field", dout[142:128], 143'h5A5A);
    chk("b_rdata_field", dout[76:45], 143'd0);
    scan_id = 1'b0; tick(4);
    pulse_chain();
    shift_frame('0, dout);
    chk("a_ctr_fields", {dout[142:128], dout[112:96]}, 143'd0);
    chk("a_rdata_again", dout[76:45], 143'hDEAD_BEEF);

    // load_chip while group A is busy is ignored
    shift_frame(mk(1'b0, 1'b1, 11'h00A, 32'h1234_5678, 1'b0, 1'b0, '0, '0, '0), dout);
    pulse_chip();
    chk("busy_wen", {sram_ren_A, sram_wen_A}, 143'd1);
    shift_frame(mk(1'b1, 1'b1, 11'h7FF, 32'hFFFF_FFFF, 1'b1, 1'b1, '0, '0, '0), dout);
    pulse_chip();
    chk("busy_reqs", {sram_ren_A, sram_wen_A, ctr_ren_A, ctr_wen_A}, 143'b0100);
    chk("busy_addr", sram_addr_A, 143'h00A);
    chk("busy_wdata", sram_wdata_A, 143'h1234_5678);
    sram_resp_a();

    // Reset in the middle of an access
    shift_frame(mk(1'b1, 1'b0, 11'h003, '0, 1'b1, 1'b0, '0, '0, 15'h4000), dout);
    pulse_chip();
    chk("pre_rst_reqs", {sram_ren_A, ctr_ren_A}, 143'b11);
    chk("pre_rst_dout", scan_data_out, 143'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_reqs", {sram_ren_A, sram_wen_A, ctr_ren_A, ctr_wen_A}, 143'd0);
    chk("rst_async_dout", scan_data_out, 143'd0);
    chk("rst_async_addr", sram_addr_A, 143'd0);
    tick(2);
    rst = 1'b0;
    tick(4);
    pulse_chain();
    shift_frame('0, dout);
    chk("post_rst_chain", dout, 143'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
